// File: rtl/lis_pkg.sv
// Shared definitions for the load-store unit: op codes, access-size decode
// and the sequencing FSM state encoding.
package lis_pkg;

  // Operation codes presented on lis_op_i.
  localparam logic [2:0] LIS_LB  = 3'd0;
  localparam logic [2:0] LIS_LH  = 3'd1;
  localparam logic [2:0] LIS_LW  = 3'd2;
  localparam logic [2:0] LIS_LBU = 3'd3;
  localparam logic [2:0] LIS_LHU = 3'd4;
  localparam logic [2:0] LIS_SB  = 3'd5;
  localparam logic [2:0] LIS_SH  = 3'd6;
  localparam logic [2:0] LIS_SW  = 3'd7;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE1 = 3'd1,
    ST_WAIT1  = 3'd2,
    ST_ISSUE2 = 3'd3,
    ST_WAIT2  = 3'd4,
    ST_DONE   = 3'd5
  } lis_state_e;

  // Number of bytes touched by an op; word ops touch the full data width.
  function automatic int unsigned lis_size(input logic [2:0] op, input int unsigned nb);
    int unsigned sz;
    case (op)
      LIS_LB, LIS_LBU, LIS_SB: sz = 32'd1;
      LIS_LH, LIS_LHU, LIS_SH: sz = 32'd2;
      default:                 sz = nb;
    endcase
    return sz;
  endfunction

  // True for the three store ops.
  function automatic logic lis_is_store(input logic [2:0] op);
    logic st;
    case (op)
      LIS_SB, LIS_SH, LIS_SW: st = 1'b1;
      default:                st = 1'b0;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/lis_lane_align.sv
// Combinational lane logic: byte enables for both beats, store-data rotation
// into the addressed lanes, and load-data assembly plus sign/zero extension.
module lis_lane_align
  import lis_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  localparam int NB         = DATA_WIDTH / 8,
  localparam int OFF_W      = $clog2(NB)
) (
  input  logic [2:0]            op,
  input  logic [OFF_W-1:0]      off,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] beat1,
  input  logic [DATA_WIDTH-1:0] beat2,
  output logic [NB-1:0]         be1,
  output logic [NB-1:0]         be2,
  output logic                  split,
  output logic [DATA_WIDTH-1:0] wdata_rot,
  output logic [DATA_WIDTH-1:0] ld_data
);

  logic [NB-1:0]           size_mask_s;
  logic [2*NB-1:0]         be_full_s;
  logic [OFF_W+2:0]        shamt_s;
  logic [2*DATA_WIDTH-1:0] wr_dbl_s;
  logic [2*DATA_WIDTH-1:0] rd_dbl_s;
  logic [DATA_WIDTH-1:0]   merged_s;
  logic [DATA_WIDTH-1:0]   aligned_s;
  int unsigned             size_s;

  assign shamt_s = {off, 3'b000};

  // Build a size-wide enable mask and shift it to the offset; bits that spill
  // past the top lane become the second-beat enables.
  always_comb begin
    size_s      = lis_size(op, NB);
    size_mask_s = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      size_mask_s[i] = (i < size_s);
    end
    be_full_s = {{NB{1'b0}}, size_mask_s} << off;
  end

  assign be1   = be_full_s[NB-1:0];
  assign be2   = be_full_s[2*NB-1:NB];
  assign split = |be2;

  // Rotate store data left by offset bytes; the doubled word makes it a plain shift.
  always_comb begin
    wr_dbl_s = {wdata, wdata} << shamt_s;
  end

  assign wdata_rot = wr_dbl_s[2*DATA_WIDTH-1:DATA_WIDTH];

  // Lanes at/above the offset come from beat 1, wrapped lanes from beat 2,
  // then rotate right by the offset so the addressed byte lands in byte 0.
  always_comb begin
    merged_s = '0;
    for (int unsigned l = 0; l < NB; l++) begin
      if (l >= 32'(off)) begin
        merged_s[8*l +: 8] = beat1[8*l +: 8];
      end else begin
        merged_s[8*l +: 8] = beat2[8*l +: 8];
      end
    end
    rd_dbl_s  = {merged_s, merged_s} >> shamt_s;
    aligned_s = rd_dbl_s[DATA_WIDTH-1:0];
  end

  // Extend the assembled load to the full data width according to the op.
  always_comb begin
    case (op)
      LIS_LB:  ld_data = {{(DATA_WIDTH-8){aligned_s[7]}}, aligned_s[7:0]};
      LIS_LH:  ld_data = {{(DATA_WIDTH-16){aligned_s[15]}}, aligned_s[15:0]};
      LIS_LBU: ld_data = {{(DATA_WIDTH-8){1'b0}}, aligned_s[7:0]};
      LIS_LHU: ld_data = {{(DATA_WIDTH-16){1'b0}}, aligned_s[15:0]};
      default: ld_data = aligned_s;
    endcase
  end

endmodule

// File: rtl/lis_seq_unit.sv
// Sequential load-store unit: accepts one core request at a time, issues one
// or two word transactions to data memory and returns a one-cycle response.
module lis_seq_unit
  import lis_pkg::*;
#(
  parameter int LIS_OP_WIDTH     = 3,
  parameter int DATA_WIDTH       = 32,
  parameter int MEM_ADDR_WIDTH   = 10,
  parameter int SPLIT_MISALIGNED = 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [LIS_OP_WIDTH-1:0]   lis_op_i,
  input  logic [DATA_WIDTH-1:0]     addr_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  output logic                      resp_valid_o,
  output logic [DATA_WIDTH-1:0]     rdata_o,
  output logic                      err_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [DATA_WIDTH/8-1:0]   mem_be_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  input  logic                      mem_gnt_i,
  input  logic                      mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

  localparam int NB       = DATA_WIDTH / 8;
  localparam int OFF_W    = $clog2(NB);
  localparam bit SPLIT_EN = (SPLIT_MISALIGNED != 0);

  lis_state_e                state_r;
  lis_state_e                state_n_s;

  logic [LIS_OP_WIDTH-1:0]   op_r;
  logic [OFF_W-1:0]          off_r;
  logic [MEM_ADDR_WIDTH-1:0] waddr_r;
  logic [DATA_WIDTH-1:0]     wdata_r;
  logic [DATA_WIDTH-1:0]     beat1_r;
  logic [DATA_WIDTH-1:0]     beat2_r;

  logic                      accept_s;
  logic [2:0]                sel_op_s;
  logic [OFF_W-1:0]          sel_off_s;
  logic [MEM_ADDR_WIDTH-1:0] sel_waddr_s;
  logic [DATA_WIDTH-1:0]     sel_wdata_s;
  logic [DATA_WIDTH-1:0]     beat1_src_s;
  logic [DATA_WIDTH-1:0]     beat2_src_s;
  logic                      is_store_s;
  logic                      reject_s;

  logic [NB-1:0]             be1_s;
  logic [NB-1:0]             be2_s;
  logic                      split_s;
  logic [DATA_WIDTH-1:0]     wdata_rot_s;
  logic [DATA_WIDTH-1:0]     ld_data_s;

  logic                      mem_req_n_s;
  logic                      mem_we_n_s;
  logic [NB-1:0]             mem_be_n_s;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_n_s;
  logic [DATA_WIDTH-1:0]     mem_wdata_n_s;
  logic                      resp_valid_n_s;
  logic [DATA_WIDTH-1:0]     rdata_n_s;
  logic                      err_n_s;

  logic                      unused_addr_s;

  // Byte-address bits above the memory word address are not decoded.
  assign unused_addr_s = ^addr_i[DATA_WIDTH-1:OFF_W+MEM_ADDR_WIDTH];

  assign req_ready_o = rstn && (state_r == ST_IDLE);
  assign accept_s    = req_valid_i && req_ready_o;

  // In the accept cycle the lane logic looks at the live request so the first
  // beat can be registered onto the bus at the same edge; afterwards it uses
  // the latched copy.
  assign sel_op_s    = accept_s ? lis_op_i[2:0] : op_r[2:0];
  assign sel_off_s   = accept_s ? addr_i[OFF_W-1:0] : off_r;
  assign sel_waddr_s = accept_s ? addr_i[OFF_W+MEM_ADDR_WIDTH-1:OFF_W] : waddr_r;
  assign sel_wdata_s = accept_s ? wdata_i : wdata_r;

  // Read data is consumed in the same cycle rvalid arrives, so the beat
  // currently being waited on bypasses its capture register.
  assign beat1_src_s = (state_r == ST_WAIT1) ? mem_rdata_i : beat1_r;
  assign beat2_src_s = (state_r == ST_WAIT2) ? mem_rdata_i : beat2_r;

  assign is_store_s = lis_is_store(sel_op_s);
  assign reject_s   = accept_s && split_s && !SPLIT_EN;

  lis_lane_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane_align (
    .op        (sel_op_s),
    .off       (sel_off_s),
    .wdata     (sel_wdata_s),
    .beat1     (beat1_src_s),
    .beat2     (beat2_src_s),
    .be1       (be1_s),
    .be2       (be2_s),
    .split     (split_s),
    .wdata_rot (wdata_rot_s),
    .ld_data   (ld_data_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Next-state decode for the issue/wait sequence.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (reject_s) begin
            state_n_s = ST_DONE;
          end else begin
            state_n_s = ST_ISSUE1;
          end
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_ISSUE1: begin
        if (mem_gnt_i) begin
          if (is_store_s) begin
            state_n_s = split_s ? ST_ISSUE2 : ST_DONE;
          end else begin
            state_n_s = ST_WAIT1;
          end
        end else begin
          state_n_s = ST_ISSUE1;
        end
      end
      ST_WAIT1: begin
        if (mem_rvalid_i) begin
          state_n_s = split_s ? ST_ISSUE2 : ST_DONE;
        end else begin
          state_n_s = ST_WAIT1;
        end
      end
      ST_ISSUE2: begin
        if (mem_gnt_i) begin
          state_n_s = is_store_s ? ST_DONE : ST_WAIT2;
        end else begin
          state_n_s = ST_ISSUE2;
        end
      end
      ST_WAIT2: begin
        if (mem_rvalid_i) begin
          state_n_s = ST_DONE;
        end else begin
          state_n_s = ST_WAIT2;
        end
      end
      ST_DONE: state_n_s = ST_IDLE;
      default: state_n_s = ST_IDLE;
    endcase
  end

  // Output decode from the next state so every bus/response output is a flop;
  // the result and error flag hold their last value between responses.
  always_comb begin
    mem_req_n_s    = 1'b0;
    mem_we_n_s     = 1'b0;
    mem_be_n_s     = '0;
    mem_addr_n_s   = '0;
    mem_wdata_n_s  = '0;
    resp_valid_n_s = 1'b0;
    rdata_n_s      = rdata_o;
    err_n_s        = err_o;
    case (state_n_s)
      ST_ISSUE1: begin
        mem_req_n_s   = 1'b1;
        mem_we_n_s    = is_store_s;
        mem_be_n_s    = be1_s;
        mem_addr_n_s  = sel_waddr_s;
        mem_wdata_n_s = wdata_rot_s;
      end
      ST_ISSUE2: begin
        mem_req_n_s   = 1'b1;
        mem_we_n_s    = is_store_s;
        mem_be_n_s    = be2_s;
        mem_addr_n_s  = sel_waddr_s + MEM_ADDR_WIDTH'(1);
        mem_wdata_n_s = wdata_rot_s;
      end
      ST_DONE: begin
        resp_valid_n_s = 1'b1;
        err_n_s        = reject_s;
        if (reject_s || is_store_s) begin
          rdata_n_s = '0;
        end else begin
          rdata_n_s = ld_data_s;
        end
      end
      default: begin
        mem_req_n_s = 1'b0;
      end
    endcase
  end

  // Registered bus and response outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_be_o     <= '0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      resp_valid_o <= 1'b0;
      rdata_o      <= '0;
      err_o        <= 1'b0;
    end else begin
      mem_req_o    <= mem_req_n_s;
      mem_we_o     <= mem_we_n_s;
      mem_be_o     <= mem_be_n_s;
      mem_addr_o   <= mem_addr_n_s;
      mem_wdata_o  <= mem_wdata_n_s;
      resp_valid_o <= resp_valid_n_s;
      rdata_o      <= rdata_n_s;
      err_o        <= err_n_s;
    end
  end

  // Latch the request at acceptance and capture each read beat on rvalid.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      op_r    <= '0;
      off_r   <= '0;
      waddr_r <= '0;
      wdata_r <= '0;
      beat1_r <= '0;
      beat2_r <= '0;
    end else begin
      if (accept_s) begin
        op_r    <= lis_op_i;
        off_r   <= addr_i[OFF_W-1:0];
        waddr_r <= addr_i[OFF_W+MEM_ADDR_WIDTH-1:OFF_W];
        wdata_r <= wdata_i;
      end
      if ((state_r == ST_WAIT1) && mem_rvalid_i) begin
        beat1_r <= mem_rdata_i;
      end
      if ((state_r == ST_WAIT2) && mem_rvalid_i) begin
        beat2_r <= mem_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_lis_seq_unit.sv
// Directed self-checking bench for lis_seq_unit: one splitting instance with a
// hand-driven memory handshake, plus a non-splitting instance for rejects.
module tb_lis_seq_unit;

  logic        clk;
  logic        rstn;

  logic        req_valid;
  logic        req_ready;
  logic [2:0]  lis_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        ns_req_valid;
  logic        ns_req_ready;
  logic [2:0]  ns_lis_op;
  logic [31:0] ns_addr;
  logic [31:0] ns_wdata;
  logic        ns_resp_valid;
  logic [31:0] ns_rdata;
  logic        ns_err;
  logic        ns_mem_req;
  logic        ns_mem_we;
  logic [3:0]  ns_mem_be;
  logic [9:0]  ns_mem_addr;
  logic [31:0] ns_mem_wdata;
  logic        ns_mem_gnt;
  logic        ns_mem_rvalid;
  logic [31:0] ns_mem_rdata;

  int n_checks;
  int n_errors;

  lis_seq_unit #(
    .LIS_OP_WIDTH(3), .DATA_WIDTH(32), .MEM_ADDR_WIDTH(10), .SPLIT_MISALIGNED(1)
  ) dut (
    .clk(clk), .rstn(rstn),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .lis_op_i(lis_op),
    .addr_i(addr), .wdata_i(wdata),
    .resp_valid_o(resp_valid), .rdata_o(rdata), .err_o(err),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );

  lis_seq_unit #(
    .LIS_OP_WIDTH(3), .DATA_WIDTH(32), .MEM_ADDR_WIDTH(10), .SPLIT_MISALIGNED(0)
  ) dut_ns (
    .clk(clk), .rstn(rstn),
    .req_valid_i(ns_req_valid), .req_ready_o(ns_req_ready), .lis_op_i(ns_lis_op),
    .addr_i(ns_addr), .wdata_i(ns_wdata),
    .resp_valid_o(ns_resp_valid), .rdata_o(ns_rdata), .err_o(ns_err),
    .mem_req_o(ns_mem_req), .mem_we_o(ns_mem_we), .mem_be_o(ns_mem_be),
    .mem_addr_o(ns_mem_addr), .mem_wdata_o(ns_mem_wdata),
    .mem_gnt_i(ns_mem_gnt), .mem_rvalid_i(ns_mem_rvalid), .mem_rdata_i(ns_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Single-beat load with zero-wait memory; request inputs are scrambled
  // after acceptance to confirm they were latched.
  task automatic load1(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] word, input logic [3:0] ebe,
                       input logic [9:0] ea, input logic [31:0] ed);
    req_valid = 1'b1; lis_op = op; addr = a;
    step();
    req_valid = 1'b0; lis_op = 3'd7; addr = 32'h0000_0FFC;
    chk({tag, "_req"},  64'({mem_req, mem_we, req_ready}), 64'(3'b100));
    chk({tag, "_addr"}, 64'(mem_addr), 64'(ea));
    chk({tag, "_be"},   64'(mem_be), 64'(ebe));
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk({tag, "_reqdrop"}, 64'({mem_req, resp_valid}), 64'(2'b00));
    mem_rvalid = 1'b1; mem_rdata = word;
    step();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    chk({tag, "_resp"},  64'({resp_valid, err}), 64'(2'b10));
    chk({tag, "_rdata"}, 64'(rdata), 64'(ed));
    step();
    chk({tag, "_pulse"}, 64'({resp_valid, req_ready}), 64'(2'b01));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0; n_errors = 0;
    rstn = 1'b0;
    req_valid = 1'b0; lis_op = 3'd0; addr = 32'h0; wdata = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    ns_req_valid = 1'b0; ns_lis_op = 3'd0; ns_addr = 32'h0; ns_wdata = 32'h0;
    ns_mem_gnt = 1'b0; ns_mem_rvalid = 1'b0; ns_mem_rdata = 32'h0;

    // Reset state, with a stale rvalid asserted throughout.
    step(); step();
    chk("rst_outs", 64'({mem_req, mem_we, mem_be, mem_addr, resp_valid, err}), 64'(0));
    chk("rst_data", 64'({rdata, mem_wdata}), 64'(0));
    chk("rst_ready", 64'({req_ready, ns_req_ready}), 64'(2'b00));
    chk("rst_ns", 64'({ns_mem_req, ns_resp_valid, ns_err, ns_rdata}), 64'(0));
    rstn = 1'b1;
    step();
    mem_rvalid = 1'b0;
    chk("idle_ready", 64'({req_ready, ns_req_ready, resp_valid, mem_req}), 64'(4'b1100));

    // Stray grant while idle is ignored.
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("idle_gnt", 64'({mem_req, resp_valid, req_ready}), 64'(3'b001));

    // Aligned loads, byte/half extension.
    load1("lw10",  3'd2, 32'h10, 32'hDEAD_BEEF, 4'b1111, 10'd4, 32'hDEAD_BEEF);
    load1("lb13",  3'd0, 32'h13, 32'h8011_2233, 4'b1000, 10'd4, 32'hFFFF_FF80);
    load1("lbu13", 3'd3, 32'h13, 32'h8011_2233, 4'b1000, 10'd4, 32'h0000_0080);
    load1("lhu12", 3'd4, 32'h12, 32'h8011_2233, 4'b1100, 10'd4, 32'h0000_8011);
    load1("lh12",  3'd1, 32'h12, 32'h8011_2233, 4'b1100, 10'd4, 32'hFFFF_8011);

    // SH at 0x0E: one beat, rotated data, response two cycles after accept.
    req_valid = 1'b1; lis_op = 3'd6; addr = 32'h0E; wdata = 32'h1234_ABCD;
    step();
    req_valid = 1'b0; wdata = 32'h0;
    chk("sh_bus", 64'({mem_req, mem_we, mem_addr, mem_be}), 64'({1'b1, 1'b1, 10'd3, 4'b1100}));
    chk("sh_wdata", 64'(mem_wdata), 64'(32'hABCD_1234));
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("sh_resp", 64'({resp_valid, err, mem_req}), 64'(3'b100));
    step();

    // Split LW at 0x0A.
    req_valid = 1'b1; lis_op = 3'd2; addr = 32'h0A;
    step();
    req_valid = 1'b0;
    chk("lwsp_b1", 64'({mem_req, mem_we, mem_addr, mem_be}), 64'({1'b1, 1'b0, 10'd2, 4'b1100}));
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h1122_3344;
    step();
    mem_rvalid = 1'b0;
    chk("lwsp_b2", 64'({mem_req, mem_we, mem_addr, mem_be}), 64'({1'b1, 1'b0, 10'd3, 4'b0011}));
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("lwsp_wait", 64'({mem_req, resp_valid}), 64'(2'b00));
    mem_rvalid = 1'b1; mem_rdata = 32'h5566_7788;
    step();
    mem_rvalid = 1'b0;
    chk("lwsp_resp", 64'({resp_valid, err, rdata}), 64'({1'b1, 1'b0, 32'h7788_1122}));
    step();

    // Split SW at word 1023, offset 2: second beat wraps to word 0.
    req_valid = 1'b1; lis_op = 3'd7; addr = 32'h0000_0FFE; wdata = 32'hA1B2_C3D4;
    step();
    req_valid = 1'b0;
    chk("swwr_b1", 64'({mem_req, mem_we, mem_addr, mem_be}), 64'({1'b1, 1'b1, 10'd1023, 4'b1100}));
    chk("swwr_wd1", 64'(mem_wdata), 64'(32'hC3D4_A1B2));
    mem_gnt = 1'b1;
    step();
    chk("swwr_b2", 64'({mem_req, mem_we, mem_addr, mem_be, resp_valid}), 64'({1'b1, 1'b1, 10'd0, 4'b0011, 1'b0}));
    chk("swwr_wd2", 64'(mem_wdata), 64'(32'hC3D4_A1B2));
    step();
    mem_gnt = 1'b0;
    chk("swwr_resp", 64'({resp_valid, err, mem_req}), 64'(3'b100));
    step();

    // Non-splitting instance rejects a misaligned LW without touching memory.
    ns_req_valid = 1'b1; ns_lis_op = 3'd2; ns_addr = 32'h02;
    step();
    ns_req_valid = 1'b0;
    chk("ns_resp", 64'({ns_resp_valid, ns_err, ns_mem_req, ns_rdata}), 64'({1'b1, 1'b1, 1'b0, 32'h0}));
    step();
    chk("ns_after", 64'({ns_resp_valid, ns_mem_req, ns_req_ready}), 64'(3'b001));

    // Grant withheld for five cycles: bus stays stable, new requests refused.
    req_valid = 1'b1; lis_op = 3'd7; addr = 32'h20; wdata = 32'hCAFE_F00D;
    step();
    lis_op = 3'd0; addr = 32'h44; wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_bus", 64'({mem_req, mem_we, mem_addr, mem_be, mem_wdata, req_ready}),
          64'({1'b1, 1'b1, 10'd8, 4'b1111, 32'hCAFE_F00D, 1'b0}));
      step();
    end
    req_valid = 1'b0; mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("stall_resp", 64'({resp_valid, err, mem_req}), 64'(3'b100));
    step();

    // Reset while waiting for read data abandons the access.
    req_valid = 1'b1; lis_op = 3'd2; addr = 32'h40;
    step();
    req_valid = 1'b0;
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("rw_wait1", 64'({mem_req, req_ready}), 64'(2'b00));
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    #1;
    chk("rw_idle", 64'({req_ready, mem_req, resp_valid}), 64'(3'b100));
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_rvalid = 1'b0;
    chk("rw_stale1", 64'({resp_valid, mem_req}), 64'(2'b00));
    step();
    chk("rw_stale2", 64'({resp_valid, mem_req, req_ready}), 64'(3'b001));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
